// File: rtl/fpu_sched.sv
// fpu_sched: single-issue sequencer that holds one op on the FPU for its latency and returns the result with its tag.
// Optional FPU_SCHED_PERF_EN adds the perf_ops/perf_busy counters.
module fpu_sched #(
    parameter int TAG_W    = 5,
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 4,
    parameter int LAT_SQRT = 4,
    parameter int LAT_MISC = 1,
    parameter int LAT_CVT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_src0,
    input  logic [31:0]      req_src1,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_src0,
    output logic [31:0]      fpu_src1,
    output logic [3:0]       fpu_op,
    input  logic [31:0]      fpu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_illegal,
    output logic             busy
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_busy
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LAT_ADD < 1 || LAT_ADD > 31 || LAT_MUL < 1 || LAT_MUL > 31 ||
        LAT_DIV < 1 || LAT_DIV > 31 || LAT_SQRT < 1 || LAT_SQRT > 31 ||
        LAT_MISC < 1 || LAT_MISC > 31 || LAT_CVT < 1 || LAT_CVT > 31) begin : g_bad_lat
        $error("fpu_sched: every latency parameter must be in 1..31");
    end

    logic [1:0]       state;
    logic [4:0]       cnt;
    logic [4:0]       lat_m1;
    logic [TAG_W-1:0] tag_q;
    logic             illegal_q;
    logic             accept;

    assign req_ready = !flush && (state == IDLE || (state == DONE && resp_ready));
    assign accept    = req_valid && req_ready;
    assign busy      = state != IDLE;

    // Countdown preload for the incoming opcode; undefined opcodes finish in one cycle.
    always_comb begin
        lat_m1 = (req_op <= 4'h1) ? 5'(LAT_ADD - 1) :
                 (req_op == 4'h2) ? 5'(LAT_MUL - 1) :
                 (req_op == 4'h3) ? 5'(LAT_DIV - 1) :
                 (req_op == 4'h4) ? 5'(LAT_SQRT - 1) :
                 (req_op <= 4'hA) ? 5'(LAT_MISC - 1) :
                 (req_op <= 4'hC) ? 5'(LAT_CVT - 1) : 5'd0;
    end

    // Sequencer: accept, hold operands while counting down, capture result, hand it off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tag_q        <= '0;
            illegal_q    <= 1'b0;
            fpu_src0     <= '0;
            fpu_src1     <= '0;
            fpu_op       <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_tag     <= '0;
            resp_illegal <= 1'b0;
        end else if (flush && state != IDLE) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
        end else if (accept) begin
            state      <= EXEC;
            cnt        <= lat_m1;
            tag_q      <= req_tag;
            illegal_q  <= req_op >= 4'hD;
            fpu_src0   <= req_src0;
            fpu_src1   <= req_src1;
            fpu_op     <= req_op;
            resp_valid <= 1'b0;
        end else if (state == EXEC) begin
            if (cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end else begin
                state        <= DONE;
                resp_valid   <= 1'b1;
                resp_data    <= illegal_q ? 32'h0 : fpu_result;
                resp_tag     <= tag_q;
                resp_illegal <= illegal_q;
            end
        end else if (state != IDLE && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end
    end

`ifdef FPU_SCHED_PERF_EN
    // Free-running activity counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (accept) perf_ops <= perf_ops + 32'd1;
            if (busy) perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed vectors, corner sequences and random traffic against a transaction-level model.
module tb_fpu_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_src0 = '0;
    logic [31:0] req_src1 = '0;
    logic [4:0]  req_tag = '0;
    logic [31:0] fpu_src0, fpu_src1, fpu_result, resp_data;
    logic [3:0]  fpu_op;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [4:0]  resp_tag;
    logic        resp_illegal;
    logic        busy;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_ops, perf_busy;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_sched dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src0(req_src0), .req_src1(req_src1), .req_tag(req_tag),
        .fpu_src0(fpu_src0), .fpu_src1(fpu_src1), .fpu_op(fpu_op), .fpu_result(fpu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_illegal(resp_illegal), .busy(busy)
`ifdef FPU_SCHED_PERF_EN
        , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
    );

    // Stand-in FPU: exact answers for the directed float cases, ordered compares, a hash otherwise.
    function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'h0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 4'h2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 4'h3 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (op == 4'h8) return {31'b0, a == b};
        if (op == 4'h9) return {31'b0, $signed(a) < $signed(b)};
        if (op == 4'hA) return {31'b0, $signed(a) <= $signed(b)};
        return (a ^ {b[15:0], b[31:16]}) + {28'b0, op} * 32'h9E3779B1;
    endfunction

    assign fpu_result = fpu_fn(fpu_op, fpu_src0, fpu_src1);

    function automatic int lat_of(input logic [3:0] op);
        if (op <= 4'h2) return 2;
        if (op <= 4'h4) return 4;
        if (op <= 4'hA) return 1;
        if (op <= 4'hC) return 2;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_src0 = a;
        req_src1 = b;
        req_tag = tag;
        #1 chk("accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic rr, output int cycles);
        resp_ready = rr;
        issue(op, a, b, tag);
        cycles = 0;
        while (!resp_valid && cycles < 40) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vt[10];

    int          cyc, m_due, cycles;
    logic        m_have, m_ill, ev, er;
    logic [31:0] m_data, m_a, m_b;
    logic [4:0]  m_tag;
    logic [3:0]  m_op;

    initial begin
        vt[0] = '{4'h0, 32'h3F800000, 32'h40000000, 5'd3,  32'h40400000, 1'b0, 2};
        vt[1] = '{4'h2, 32'h40000000, 32'h40400000, 5'd9,  32'h40C00000, 1'b0, 2};
        vt[2] = '{4'h3, 32'h40C00000, 32'h40000000, 5'd17, 32'h40400000, 1'b0, 4};
        vt[3] = '{4'h9, 32'h3F800000, 32'h40000000, 5'd21, 32'h00000001, 1'b0, 1};
        vt[4] = '{4'hE, 32'h12345678, 32'h9ABCDEF0, 5'd30, 32'h00000000, 1'b1, 1};
        vt[5] = '{4'h8, 32'h3F800000, 32'h3F800000, 5'd4,  32'h00000001, 1'b0, 1};
        vt[6] = '{4'hD, 32'hFFFFFFFF, 32'h00000001, 5'd31, 32'h00000000, 1'b1, 1};
        vt[7] = '{4'hB, 32'hC0A00000, 32'h0,        5'd6,  fpu_fn(4'hB, 32'hC0A00000, 32'h0), 1'b0, 2};
        vt[8] = '{4'h4, 32'h41100000, 32'h0,        5'd11, fpu_fn(4'h4, 32'h41100000, 32'h0), 1'b0, 4};
        vt[9] = '{4'hF, 32'hDEADBEEF, 32'hCAFEF00D, 5'd0,  32'h00000000, 1'b1, 1};

        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_fpu_op", {28'b0, fpu_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, 1'b1, cycles);
            chk($sformatf("vec%0d_latency", i), cycles, vt[i].lat);
            chk($sformatf("vec%0d_data", i), resp_data, vt[i].data);
            chk($sformatf("vec%0d_tag", i), {27'b0, resp_tag}, {27'b0, vt[i].tag});
            chk($sformatf("vec%0d_illegal", i), {31'b0, resp_illegal}, {31'b0, vt[i].ill});
            @(posedge clk);
            #1 chk($sformatf("vec%0d_drop", i), {31'b0, resp_valid}, 32'd0);
        end

        run_op(4'h3, 32'h40C00000, 32'h40000000, 5'd7, 1'b0, cycles);
        chk("hold_latency", cycles, 32'd4);
        req_valid = 1'b1;
        req_op = 4'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("hold_data", resp_data, 32'h40400000);
            chk("hold_tag", {27'b0, resp_tag}, 32'd7);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        resp_ready = 1'b1;
        #1 chk("hold_valid_last", {31'b0, resp_valid}, 32'd1);
        @(posedge clk);
        #1 chk("hold_drop", {31'b0, resp_valid}, 32'd0);
        chk("hold_idle", {31'b0, busy}, 32'd0);

        run_op(4'h2, 32'h40000000, 32'h40400000, 5'd1, 1'b1, cycles);
        chk("b2b_lat1", cycles, 32'd2);
        req_valid = 1'b1;
        req_op = 4'h9;
        req_src0 = 32'h3F800000;
        req_src1 = 32'h40000000;
        req_tag = 5'd2;
        #1;
        chk("b2b_ready", {31'b0, req_ready}, 32'd1);
        chk("b2b_data1", resp_data, 32'h40C00000);
        chk("b2b_tag1", {27'b0, resp_tag}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("b2b_gap_valid", {31'b0, resp_valid}, 32'd0);
        chk("b2b_gap_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1 chk("b2b_valid2", {31'b0, resp_valid}, 32'd1);
        chk("b2b_data2", resp_data, 32'h00000001);
        chk("b2b_tag2", {27'b0, resp_tag}, 32'd2);
        @(posedge clk);
        #1 chk("b2b_drop", {31'b0, resp_valid}, 32'd0);

        issue(4'h4, 32'h41100000, 32'h0, 5'd12);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        cycles = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (resp_valid) cycles++;
        end
        chk("flush_no_resp", cycles, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        #1 chk("flush_idle_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1 chk("flush_idle_busy", {31'b0, busy}, 32'd0);
        flush = 1'b0;
        req_valid = 1'b0;

        issue(4'h3, 32'h40C00000, 32'h40000000, 5'd5);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_valid", {31'b0, resp_valid}, 32'd0);
        chk("arst_data", resp_data, 32'd0);
        chk("arst_tag", {27'b0, resp_tag}, 32'd0);
        chk("arst_src0", fpu_src0, 32'd0);
        chk("arst_src1", fpu_src1, 32'd0);
        chk("arst_op", {28'b0, fpu_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (resp_valid) cycles++;
        end
        chk("arst_no_resp", cycles, 32'd0);

        run_op(4'h0, 32'h3F800000, 32'h40000000, 5'd1, 1'b1, cycles);
        @(posedge clk);
        run_op(4'h2, 32'h40000000, 32'h40400000, 5'd2, 1'b1, cycles);
        @(posedge clk);
        run_op(4'h8, 32'h3F800000, 32'h3F800000, 5'd3, 1'b1, cycles);
        @(posedge clk);
`ifdef FPU_SCHED_PERF_EN
        #1;
        chk("perf_ops", perf_ops, 32'd3);
        chk("perf_busy", perf_busy, 32'd8);
`endif

        cyc = 0;
        m_have = 1'b0;
        m_due = 0;
        m_data = '0;
        m_tag = '0;
        m_ill = 1'b0;
        m_op = '0;
        m_a = '0;
        m_b = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            flush = ($urandom_range(15) == 0);
            req_valid = 1'($urandom_range(1));
            resp_ready = ($urandom_range(3) != 0);
            req_op = 4'($urandom_range(15));
            req_src0 = $urandom;
            req_src1 = ($urandom_range(3) == 0) ? req_src0 : $urandom;
            req_tag = 5'($urandom);
            #1;
            ev = m_have && cyc >= m_due;
            er = !flush && (!m_have || (ev && resp_ready));
            chk("rnd_req_ready", {31'b0, req_ready}, {31'b0, er});
            chk("rnd_resp_valid", {31'b0, resp_valid}, {31'b0, ev});
            chk("rnd_busy", {31'b0, busy}, {31'b0, m_have});
            if (ev) begin
                chk("rnd_data", resp_data, m_data);
                chk("rnd_tag", {27'b0, resp_tag}, {27'b0, m_tag});
                chk("rnd_illegal", {31'b0, resp_illegal}, {31'b0, m_ill});
            end
            if (m_have) begin
                chk("rnd_fpu_op", {28'b0, fpu_op}, {28'b0, m_op});
                chk("rnd_fpu_src0", fpu_src0, m_a);
                chk("rnd_fpu_src1", fpu_src1, m_b);
            end
            cyc++;
            if (flush) begin
                m_have = 1'b0;
            end else begin
                if (ev && resp_ready) m_have = 1'b0;
                if (req_valid && er) begin
                    m_have = 1'b1;
                    m_due = cyc + lat_of(req_op);
                    m_op = req_op;
                    m_a = req_src0;
                    m_b = req_src1;
                    m_tag = req_tag;
                    m_ill = req_op >= 4'hD;
                    m_data = m_ill ? 32'h0 : fpu_fn(req_op, req_src0, req_src1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
